// File: rtl/serial_add_ctrl.sv
// Bit-serial adder controller: one shared full adder is stepped over WIDTH cycles,
// LSB first, with the carry recirculated through a flip-flop.

module full_adder (
    output logic sum_o,
    output logic cout_o,
    input  logic a_i,
    input  logic b_i,
    input  logic c_i
);
    assign sum_o  = a_i ^ b_i ^ c_i;
    assign cout_o = (a_i & b_i) | (c_i & (a_i ^ b_i));
endmodule

module serial_add_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             cin_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] sum_o,
    output logic             cout_o
);
    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   a_sr_q, a_sr_d;
    logic [WIDTH-1:0]   b_sr_q, b_sr_d;
    logic               carry_q, carry_d;
    logic [WIDTH-1:0]   sum_q, sum_d;
    logic               cout_q, cout_d;

    logic               fa_sum;
    logic               fa_cout;
    logic [WIDTH-1:0]   res_full;

    full_adder u_fa (
        .sum_o  (fa_sum),
        .cout_o (fa_cout),
        .a_i    (a_sr_q[0]),
        .b_i    (b_sr_q[0]),
        .c_i    (carry_q)
    );

    // res_full is the result register after this edge's shift; only WIDTH-1 bits
    // need storing because the newest bit comes straight from the adder.
    generate
        if (WIDTH == 1) begin : g_res_w1
            assign res_full = fa_sum;
        end else begin : g_res_wn
            logic [WIDTH-2:0] res_sr_q;

            assign res_full = {fa_sum, res_sr_q};

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    res_sr_q <= '0;
                end else if (state_q == S_RUN) begin
                    res_sr_q <= res_full[WIDTH-1:1];
                end
            end
        end
    endgenerate

    always_comb begin
        // NOTE: every next-state signal defaults to its held value so no path infers a latch.
        state_d = state_q;
        cnt_d   = cnt_q;
        a_sr_d  = a_sr_q;
        b_sr_d  = b_sr_q;
        carry_d = carry_q;
        sum_d   = sum_q;
        cout_d  = cout_q;

        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    a_sr_d  = a_i;
                    b_sr_d  = b_i;
                    carry_d = cin_i;
                    cnt_d   = '0;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                a_sr_d  = a_sr_q >> 1;
                b_sr_d  = b_sr_q >> 1;
                carry_d = fa_cout;
                cnt_d   = cnt_q + CNT_W'(1);
                if (cnt_q == LAST_BIT) begin
                    sum_d   = res_full;
                    cout_d  = fa_cout;
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            a_sr_q  <= '0;
            b_sr_q  <= '0;
            carry_q <= 1'b0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_sr_q  <= a_sr_d;
            b_sr_q  <= b_sr_d;
            carry_q <= carry_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
        end
    end

    assign busy_o = (state_q != S_IDLE);
    assign done_o = (state_q == S_DONE);
    assign sum_o  = sum_q;
    assign cout_o = cout_q;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Directed and random checks of serial_add_ctrl at WIDTH=8 and WIDTH=1.

module tb_serial_add_ctrl;
    logic       clk;
    logic       rst;

    logic       start8, cin8, busy8, done8, cout8;
    logic [7:0] a8, b8, sum8;

    logic       start1, cin1, busy1, done1, cout1;
    logic [0:0] a1, b1, sum1;

    int tests_run;
    int tests_failed;
    logic prev_done8;

    serial_add_ctrl #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .start_i(start8), .a_i(a8), .b_i(b8), .cin_i(cin8),
        .busy_o(busy8), .done_o(done8), .sum_o(sum8), .cout_o(cout8)
    );

    serial_add_ctrl #(.WIDTH(1)) dut1 (
        .clk(clk), .rst(rst), .start_i(start1), .a_i(a1), .b_i(b1), .cin_i(cin1),
        .busy_o(busy1), .done_o(done1), .sum_o(sum1), .cout_o(cout1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // done must never stay high for two consecutive cycles.
    initial prev_done8 = 1'b0;
    always @(negedge clk) begin
        if (done8 === 1'b1) check("done_single", prev_done8, 1'b0);
        prev_done8 = done8;
    end

    // Start one WIDTH=8 add, wait for done within a bounded window, check the result.
    task automatic run8(input logic [7:0] a, input logic [7:0] b, input logic c, input string tag);
        logic [8:0] exp;
        int n;
        exp = {1'b0, a} + {1'b0, b} + {8'd0, c};
        a8 = a; b8 = b; cin8 = c; start8 = 1'b1;
        tick();
        start8 = 1'b0;
        check({tag, "_busy"}, busy8, 1'b1);
        check({tag, "_done_early"}, done8, 1'b0);
        n = 0;
        while (done8 !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        check({tag, "_latency"}, n, 8);
        check({tag, "_sum"}, sum8, exp[7:0]);
        check({tag, "_cout"}, cout8, exp[8]);
        tick();
        check({tag, "_done_clr"}, done8, 1'b0);
        check({tag, "_busy_clr"}, busy8, 1'b0);
    endtask

    task automatic run1(input logic a, input logic b, input logic c, input string tag);
        logic [1:0] exp;
        exp = {1'b0, a} + {1'b0, b} + {1'b0, c};
        a1 = a; b1 = b; cin1 = c; start1 = 1'b1;
        tick();
        start1 = 1'b0;
        check({tag, "_busy"}, busy1, 1'b1);
        check({tag, "_done_early"}, done1, 1'b0);
        tick();
        check({tag, "_done"}, done1, 1'b1);
        check({tag, "_sum"}, sum1, exp[0]);
        check({tag, "_cout"}, cout1, exp[1]);
        tick();
        check({tag, "_done_clr"}, done1, 1'b0);
        check({tag, "_busy_clr"}, busy1, 1'b0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        tests_run = 0;
        tests_failed = 0;
        rst = 1'b1;
        start8 = 1'b0; a8 = '0; b8 = '0; cin8 = 1'b0;
        start1 = 1'b0; a1 = '0; b1 = '0; cin1 = 1'b0;

        tick();
        tick();
        check("rst_busy", busy8, 1'b0);
        check("rst_done", done8, 1'b0);
        check("rst_sum", sum8, 8'h00);
        check("rst_cout", cout8, 1'b0);
        rst = 1'b0;
        tick();

        // Carry-in only
        run8(8'h00, 8'h00, 1'b1, "cin_only");

        // Full carry ripple, then a back-to-back op at the first IDLE cycle
        run8(8'hFF, 8'h01, 1'b0, "ripple");
        run8(8'hA5, 8'h5A, 1'b1, "b2b");

        // start held high: second op takes the a/b present at its accept edge
        a8 = 8'h3C; b8 = 8'h42; cin8 = 1'b0; start8 = 1'b1;
        for (int t = 1; t <= 20; t++) begin
            tick();
            if (t == 3) begin
                a8 = 8'h11;
                b8 = 8'h22;
            end
            check($sformatf("hold_done_t%0d", t), done8, (t == 9 || t == 19));
            if (t >= 9 && t <= 18) check($sformatf("hold_sum_t%0d", t), sum8, 8'h7E);
            if (t == 9) check("hold_cout1", cout8, 1'b0);
            if (t == 19) begin
                check("hold_sum2", sum8, 8'h33);
                check("hold_cout2", cout8, 1'b0);
            end
        end
        start8 = 1'b0;
        tick();
        check("hold_idle", busy8, 1'b0);

        // Asynchronous reset after 4 bits of a run
        a8 = 8'h55; b8 = 8'h0F; cin8 = 1'b0; start8 = 1'b1;
        tick();
        start8 = 1'b0;
        repeat (4) tick();
        check("abort_busy_pre", busy8, 1'b1);
        #2 rst = 1'b1;
        #1;
        check("abort_busy", busy8, 1'b0);
        check("abort_done", done8, 1'b0);
        check("abort_sum", sum8, 8'h00);
        check("abort_cout", cout8, 1'b0);
        tick();
        tick();
        rst = 1'b0;
        for (int t = 0; t < 12; t++) begin
            tick();
            check("abort_no_done", done8, 1'b0);
        end
        run8(8'h80, 8'h80, 1'b0, "post_rst");

        // WIDTH=1 instance
        run1(1'b1, 1'b1, 1'b1, "w1_111");
        run1(1'b1, 1'b0, 1'b0, "w1_100");

        // Random sweep
        for (int i = 0; i < 200; i++) begin
            run8(8'($urandom), 8'($urandom), 1'($urandom), "rand");
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
